// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_if
//  Description : Single-word request/response memory bus between the
//                multicycle processor (master) and its memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Unified instruction/data memory answering the processor bus.
//                Accepts one word request, waits WAIT_CYCLES cycles, performs
//                the access and returns a one-cycle response strobe.
//                Optional macro MEM_RESPONDER_CLEAR_EN: reset sweeps the
//                array to zero (one word per cycle) before accepting requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic       clk,
  input  wire logic       reset,
  mem_responder_if.slave  bus
);

  localparam int         c_DEPTH     = 1 << DEPTH_LOG2;
  // WAIT_CYCLES == 0 never uses the load value; guard keeps it non-negative.
  localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic                  w_accept;
  logic                  w_enter_resp;

  logic                  r_write;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic                  w_acc_write;
  logic [31:0]           w_acc_addr;
  logic [31:0]           w_acc_wdata;
  logic                  w_err;
  logic [DEPTH_LOG2-1:0] w_idx;

  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_mem_idx;
  logic [31:0]           w_mem_wdata;
  logic [31:0]           r_mem [0:c_DEPTH-1];

`ifdef MEM_RESPONDER_CLEAR_EN
  localparam logic [DEPTH_LOG2-1:0] c_IDX_LAST = {DEPTH_LOG2{1'b1}};
  localparam logic [DEPTH_LOG2-1:0] c_IDX_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  logic [DEPTH_LOG2-1:0] r_clr_idx;
`endif

  assign w_accept      = bus.req_valid && (r_state == S_IDLE);
  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

  // With zero wait states the access happens on the acceptance edge, so the
  // live bus is used; otherwise the captured request is used.
  assign w_acc_write = (r_state == S_IDLE) ? bus.req_write : r_write;
  assign w_acc_addr  = (r_state == S_IDLE) ? bus.req_addr  : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? bus.req_wdata : r_wdata;

  assign w_err = (|w_acc_addr[1:0]) || (|w_acc_addr[31:DEPTH_LOG2+2]);
  assign w_idx = w_acc_addr[DEPTH_LOG2+1:2];

  // Next-state and wait-counter logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      S_CLEAR: begin
`ifdef MEM_RESPONDER_CLEAR_EN
        if (r_clr_idx == c_IDX_LAST) begin
          w_state_nxt = S_IDLE;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef MEM_RESPONDER_CLEAR_EN
      r_state <= S_CLEAR;
`else
      r_state <= S_IDLE;
`endif
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_enter_resp) begin
        r_err <= w_err;
        if (w_err) begin
          r_rdata <= 32'd0;
        end else if (w_acc_write) begin
          r_rdata <= w_acc_wdata;
        end else begin
          r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // Request holding registers, captured on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_write <= bus.req_write;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  end

`ifdef MEM_RESPONDER_CLEAR_EN
  // Clear sweep pointer; reset restarts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_idx <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_idx <= r_clr_idx + c_IDX_ONE;
    end
  end
`endif

  // Array write port select: committed bus write or clear sweep.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = w_idx;
    w_mem_wdata = w_acc_wdata;
    if (w_enter_resp && w_acc_write && !w_err) begin
      w_mem_we = 1'b1;
    end
`ifdef MEM_RESPONDER_CLEAR_EN
    if (r_state == S_CLEAR) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = r_clr_idx;
      w_mem_wdata = 32'd0;
    end
`endif
  end

  // Array storage; reset blocks any write so a pending request never commits.
  always_ff @(posedge clk) begin
    if (w_mem_we && !reset) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder. Two instances:
//                A (DEPTH_LOG2=8, WAIT_CYCLES=2) and B (DEPTH_LOG2=4,
//                WAIT_CYCLES=0). A request-level model predicts every output
//                each cycle; directed sequences add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  mem_responder_if ifa ();
  mem_responder_if ifb ();

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut_a (.clk(clk), .reset(reset), .bus(ifa));
  mem_responder #(.DEPTH_LOG2(4), .WAIT_CYCLES(0)) u_dut_b (.clk(clk), .reset(reset), .bus(ifb));

  wire [1:0]  t_rv  = {ifb.rsp_valid, ifa.rsp_valid};
  wire [1:0]  t_rdy = {ifb.req_ready, ifa.req_ready};
  wire [1:0]  t_er  = {ifb.rsp_err,   ifa.rsp_err};
  wire [1:0]  t_iv  = {ifb.req_valid, ifa.req_valid};
  wire [1:0]  t_iw  = {ifb.req_write, ifa.req_write};
  wire [31:0] t_rd [2];
  wire [31:0] t_ia [2];
  wire [31:0] t_id [2];
  assign t_rd[0] = ifa.rsp_rdata;  assign t_rd[1] = ifb.rsp_rdata;
  assign t_ia[0] = ifa.req_addr;   assign t_ia[1] = ifb.req_addr;
  assign t_id[0] = ifa.req_wdata;  assign t_id[1] = ifb.req_wdata;

  int    n_vec = 0;
  int    n_err = 0;
  string nm [2] = '{"A", "B"};

  function automatic int wc(input int i); return (i == 0) ? 2 : 0; endfunction
  function automatic int dl(input int i); return (i == 0) ? 8 : 4; endfunction

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", what, act, exp);
    end
  endtask

  // ---------------- request-level reference model ----------------
  int          e = 1;            // number of the upcoming rising edge
  int          free_at [2];      // first edge at which a request may be accepted
  int          due     [2];      // edge after which the response is visible
  bit          pend    [2];
  bit          pw      [2];
  logic [31:0] pa      [2];
  logic [31:0] pd      [2];
  bit          started [2];
  bit          lknown  [2];
  logic [31:0] lrd     [2];
  bit          ler     [2];
  bit          clr     [2];
  bit [31:0]   mmem [int];

  initial begin
    for (int i = 0; i < 2; i++) begin
      started[i] = 0; pend[i] = 0; clr[i] = 0; lknown[i] = 0;
      free_at[i] = 0; due[i] = 0; pw[i] = 0; pa[i] = '0; pd[i] = '0;
      lrd[i] = '0; ler[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit ev;
        int key;
        bit berr;
        if (started[i]) begin
          ev = pend[i] && (due[i] == e - 1);
          if (ev) begin
            berr = (pa[i][1:0] != 2'b00) || ((pa[i] >> (dl(i) + 2)) != 0);
            key  = i * 65536 + int'((pa[i] >> 2) & ((32'd1 << dl(i)) - 1));
            pend[i] = 0;
            if (berr) begin
              lrd[i] = 32'd0; ler[i] = 1; lknown[i] = 1;
            end else if (pw[i]) begin
              mmem[key] = pd[i]; lrd[i] = pd[i]; ler[i] = 0; lknown[i] = 1;
            end else begin
              ler[i] = 0;
              if (mmem.exists(key)) begin lrd[i] = mmem[key]; lknown[i] = 1; end
              else if (clr[i])      begin lrd[i] = 32'd0;     lknown[i] = 1; end
              else                  lknown[i] = 0;
            end
          end
          chk({nm[i], ".rsp_valid"}, t_rv[i], ev);
          chk({nm[i], ".req_ready"}, t_rdy[i], (e >= free_at[i]));
          chk({nm[i], ".rsp_err"}, t_er[i], ler[i]);
          if (lknown[i]) chk({nm[i], ".rsp_rdata"}, t_rd[i], lrd[i]);
        end
        // predict what the upcoming edge does
        if (reset) begin
          started[i] = 1; pend[i] = 0; free_at[i] = e + 1;
          lrd[i] = 32'd0; ler[i] = 0; lknown[i] = 1;
`ifdef MEM_RESPONDER_CLEAR_EN
          free_at[i] = e + (1 << dl(i)) + 1;
          clr[i] = 1;
          for (int k = 0; k < (1 << dl(i)); k++)
            if (mmem.exists(i * 65536 + k)) mmem.delete(i * 65536 + k);
`endif
        end else if (started[i] && t_iv[i] && (e >= free_at[i])) begin
          pend[i] = 1; pw[i] = t_iw[i]; pa[i] = t_ia[i]; pd[i] = t_id[i];
          due[i] = e + wc(i); free_at[i] = e + wc(i) + 2;
        end
      end
      e++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int i, input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (i == 0) begin
      ifa.req_valid = v; ifa.req_write = w; ifa.req_addr = a; ifa.req_wdata = d;
    end else begin
      ifb.req_valid = v; ifb.req_write = w; ifb.req_addr = a; ifb.req_wdata = d;
    end
  endtask

  // Issues one request and returns the response plus its latency in cycles
  // counted from the acceptance edge.
  task automatic do_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    bit ok;
    @(posedge clk); #2;
    drive(i, 1'b1, w, a, d);
    ok = 0; n = 0;
    while (!ok && n < 400) begin
      @(negedge clk); n++;
      if (t_rdy[i]) ok = 1;
    end
    @(posedge clk); #2;
    drive(i, 1'b0, 1'b0, 32'd0, 32'd0);
    chk({nm[i], ".accept_in_time"}, ok, 1);
    lat = 0; ok = 0; rd = '0; er = 1'b0;
    while (!ok && lat < 40) begin
      @(negedge clk); lat++;
      if (t_rv[i]) begin ok = 1; rd = t_rd[i]; er = t_er[i]; end
    end
    chk({nm[i], ".rsp_in_time"}, ok, 1);
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (!t_rdy[i] && n < 400) begin @(negedge clk); n++; end
    chk({nm[i], ".ready_after_reset"}, t_rdy[i], 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    int          cnt;
    bit          ok;
    logic [31:0] ba [3];
    logic [31:0] bd [3];
    int          acc [3];

    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

    // reset held for two edges
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    n = 0;
    while (n < 600) begin
      @(negedge clk);
      if (t_rdy[1]) break;
      n++;
    end
`ifdef MEM_RESPONDER_CLEAR_EN
    chk("B.clear_ready_low_cycles", n, 16);
    chk("A.ready_during_clear", t_rdy[0], 0);
`else
    chk("B.ready_low_cycles", n, 0);
    chk("A.ready_after_reset", t_rdy[0], 1);
`endif
    chk("A.rsp_valid_reset", t_rv[0], 0);
    chk("B.rsp_valid_reset", t_rv[1], 0);
    chk("A.rsp_rdata_reset", t_rd[0], 32'd0);
    chk("B.rsp_rdata_reset", t_rd[1], 32'd0);
    chk("A.rsp_err_reset", t_er[0], 0);
    chk("B.rsp_err_reset", t_er[1], 0);
    wait_ready(0);

    // write then read on A (two wait states)
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("A.wr10_latency", lat, 3);
    chk("A.wr10_err", er, 0);
    chk("A.wr10_echo", rd, 32'hDEADBEEF);
    do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("A.rd10_latency", lat, 3);
    chk("A.rd10_err", er, 0);
    chk("A.rd10_data", rd, 32'hDEADBEEF);

    // misaligned write must not touch the array
    do_req(0, 1'b1, 32'h12, 32'hCAFEF00D, rd, er, lat);
    chk("A.wr12_err", er, 1);
    chk("A.wr12_rdata", rd, 32'd0);
    do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("A.rd10_after_bad_wr", rd, 32'hDEADBEEF);

    // out of range on A (256 words -> 0x400 is past the end)
    do_req(0, 1'b0, 32'h400, 32'h0, rd, er, lat);
    chk("A.rd400_err", er, 1);
    chk("A.rd400_rdata", rd, 32'd0);
    // last word in range
    do_req(0, 1'b1, 32'h3FC, 32'hA5A5_5A5A, rd, er, lat);
    chk("A.wr3fc_err", er, 0);

    // back-to-back writes on B with req_valid held high
    ba[0] = 32'h0; ba[1] = 32'h4; ba[2] = 32'h8;
    bd[0] = 32'h1111_1111; bd[1] = 32'h2222_2222; bd[2] = 32'h3333_3333;
    @(posedge clk); #2;
    drive(1, 1'b1, 1'b1, ba[0], bd[0]);
    for (int k = 0; k < 3; k++) begin
      ok = 0; n = 0;
      while (!ok && n < 20) begin
        @(negedge clk); n++;
        if (t_rdy[1]) ok = 1;
      end
      chk("B.b2b_accept", ok, 1);
      acc[k] = tcyc;
      @(posedge clk); #2;
      if (k < 2) drive(1, 1'b1, 1'b1, ba[k+1], bd[k+1]);
      else       drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      chk("B.b2b_rsp_valid", t_rv[1], 1);
      chk("B.b2b_echo", t_rd[1], bd[k]);
    end
    chk("B.b2b_spacing01", acc[1] - acc[0], 2);
    chk("B.b2b_spacing12", acc[2] - acc[1], 2);
    for (int k = 0; k < 3; k++) begin
      do_req(1, 1'b0, ba[k], 32'h0, rd, er, lat);
      chk("B.readback_latency", lat, 1);
      chk("B.readback_data", rd, bd[k]);
      chk("B.readback_err", er, 0);
    end
    // out of range on B (16 words -> 0x40 is past the end)
    do_req(1, 1'b0, 32'h40, 32'h0, rd, er, lat);
    chk("B.rd40_err", er, 1);

    // reset while A is in WAIT discards the write
    @(posedge clk); #2;
    drive(0, 1'b1, 1'b1, 32'h20, 32'h0000_1234);
    ok = 0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk); n++;
      if (t_rdy[0]) ok = 1;
    end
    chk("A.rst_wr_accept", ok, 1);
    @(posedge clk); #2;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (t_rv[0]) cnt++;
    end
    chk("A.no_rsp_after_reset", cnt, 0);
    wait_ready(0);
    wait_ready(1);
    do_req(0, 1'b0, 32'h20, 32'h0, rd, er, lat);
    n_vec++;
    if (rd === 32'h0000_1234) begin
      n_err++;
      $display("FAIL A.rd20_discarded: got 0x%08h, must differ from 0x00001234", rd);
    end
`ifdef MEM_RESPONDER_CLEAR_EN
    chk("A.rd20_cleared", rd, 32'd0);
    do_req(1, 1'b0, 32'h3C, 32'h0, rd, er, lat);
    chk("B.rd3c_cleared", rd, 32'd0);
    chk("B.rd3c_err", er, 0);
`endif

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Unified instruction/data memory that answers the multicycle processor's memory bus.
- The processor (controller + datapath) is the initiator: it issues one word read or write at a time.
- This block accepts the request, inserts a fixed number of wait states, performs the access on a word-addressed internal array, and returns a one-cycle response.
- It replaces the zero-latency behavioural memory so the controller FSM can be exercised against real memory latency.

Parameters:
- DEPTH_LOG2, 8, log2 of the number of 32-bit words in the array (default 256 words).
- WAIT_CYCLES, 2, number of WAIT-state cycles between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_write  input  1  1 = write, 0 = read; sampled with req_valid.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- req_ready  output  1  block can accept a request this cycle.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  read data; valid when rsp_valid is high.
- rsp_err  output  1  request was misaligned or out of range; valid when rsp_valid is high.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state = IDLE, wait counter = 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. Array contents are not reset, unless the optional feature is enabled.
- Handshake: a request is accepted on a rising edge where req_valid & req_ready. req_addr, req_wdata and req_write are captured into holding registers at that edge. Later changes to the inputs are ignored until the block returns to IDLE.
- State IDLE:
  - req_ready = 1.
  - On acceptance: go to RESP if WAIT_CYCLES == 0; otherwise load counter = WAIT_CYCLES - 1 and go to WAIT.
- State WAIT:
  - req_ready = 0.
  - Counter decrements each cycle. When the counter is 0, go to RESP.
- State RESP:
  - Lasts exactly 1 cycle. rsp_valid = 1 and req_ready = 0.
  - Always returns to IDLE on the next edge.
  - rsp_valid is a strobe with no backpressure; the initiator must sample it.
- Latency and throughput:
  - rsp_valid goes high exactly WAIT_CYCLES + 1 cycles after the acceptance edge.
  - Minimum request spacing is WAIT_CYCLES + 2 cycles.
- Address decode:
  - Word index = addr[DEPTH_LOG2+1:2].
  - Error if addr[1:0] != 0 (misaligned).
  - Error if addr[31:DEPTH_LOG2+2] != 0 (out of range).
- Access timing:
  - The access is performed on the edge that enters RESP.
  - Read: rsp_rdata is registered from array[index].
  - Write: array[index] <= wdata, and rsp_rdata is loaded with wdata (write-through echo).
- Error response: no array write, rsp_rdata = 0, rsp_err = 1. Otherwise rsp_err = 0.
- Outside RESP: rsp_rdata and rsp_err hold their last values; rsp_valid = 0.
- Read-after-write: a read issued after a write response returns the newly written value.
- Reset mid-operation: a pending request is discarded, including any uncommitted write. The FSM returns to IDLE and no rsp_valid is produced.
- req_valid while req_ready = 0: ignored, not queued.

Optional Feature:
- Macro: MEM_RESPONDER_CLEAR_EN.
- Defined:
  - Reset (synchronous) moves the FSM to state CLEAR instead of IDLE.
  - CLEAR writes 0 to one word per cycle, index 0 upward.
  - req_ready = 0 throughout CLEAR, which lasts exactly 2^DEPTH_LOG2 cycles after reset deasserts, then enters IDLE.
  - Reset asserted during CLEAR restarts the sweep at index 0.
- Not defined: no CLEAR state. IDLE is entered directly and array contents are unknown after reset.

Test Plan:
- Reset, then idle: reset high 2 cycles -> req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Write then read, WAIT_CYCLES = 2:
  - Write addr 0x10, data 0xDEADBEEF -> rsp_valid 3 cycles after acceptance, rsp_err = 0, rsp_rdata = 0xDEADBEEF.
  - Read 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Errors:
  - Write 0x12 (misaligned) -> rsp_err = 1, rsp_rdata = 0, word 0x10 unchanged.
  - Read 0x400 with DEPTH_LOG2 = 8 -> rsp_err = 1.
- Back-to-back requests with req_valid held high, WAIT_CYCLES = 0:
  - Each response arrives 1 cycle after acceptance.
  - Acceptances are every 2 cycles; req_ready toggles 1/0.
  - Writes to 0x0, 0x4, 0x8 read back correctly.
- Reset mid-operation: accept a write to 0x20 (data 0x1234), assert reset in WAIT -> no rsp_valid, and a later read of 0x20 does not return 0x1234.
- MEM_RESPONDER_CLEAR_EN defined, DEPTH_LOG2 = 4:
  - After reset, req_ready stays 0 for 16 cycles.
  - A read of 0x3C then returns 0x00000000.
